scope_dec_avg_sat: RTL and testbench
====================================

Name: scope_dec_avg_sat

Overview:
Decimator placed directly downstream of the scope equalization filter. It consumes the filtered 16-bit sample stream and emits one sample per cfg_dec accepted inputs. Each output is either the block average (sum shifted right by cfg_shr, then saturated) or the last sample of the block. Its output feeds the acquisition/trigger logic.

Parameters:
DWI, 16, input sample width (signed)
DWO, 16, output sample width (signed)
CW, 17, decimation counter width; cfg_dec range 0..2**CW-1
SW, 5, shift amount width

Ports:
ACLK  in  1  clock
ctl_rst  in  1  synchronous active-high reset
cfg_avg  in  1  1 = average mode, 0 = pick-last mode
cfg_dec  in  CW  decimation factor; 0 is treated as 1
cfg_shr  in  SW  average right shift, legal range 0..CW
sti_TDATA  in  DWI  input sample, signed
sti_TVALID  in  1  input valid
sti_TREADY  out  1  input ready
sto_TDATA  out  DWO  output sample, signed
sto_TVALID  out  1  output valid
sto_TREADY  in  1  output ready

Behaviour:
- Reset (ctl_rst=1 at a clock edge) clears the following to 0: cnt, acc, sto_TDATA, sto_TVALID. Reset takes priority over every other event. A block that is partly accumulated when reset hits is discarded, and no output is produced for it.
- Input transfer: sti_TVALID & sti_TREADY. Output transfer: sto_TVALID & sto_TREADY.
- sti_TREADY = sto_TREADY | ~sto_TVALID. This is combinational and gives single-register skid-free backpressure.
- Effective factor: D = (cfg_dec==0) ? 1 : cfg_dec.
- Counter cnt (CW bits):
  - On each input transfer, if cnt >= D-1, the transfer is the last sample of the block: cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Using >= (not ==) means that shrinking cfg_dec mid-block closes the block on the next input transfer, with no overflow.
- Accumulator acc (signed, DWI+CW bits, sign-extended input):
  - First sample of a block (cnt==0): acc <= x.
  - Other samples: acc <= acc + x.
  - Last sample: the sum used for output is acc_prev + x, or x if D==1.
  - acc never overflows for D <= 2**CW-1.
- Output computation on the last sample:
  - Average mode: y = sum >>> cfg_shr, arithmetic shift.
  - Pick-last mode: y = x, sign-extended.
  - Saturation to DWO: if y > 2**(DWO-1)-1, output 2**(DWO-1)-1. If y < -2**(DWO-1), output -2**(DWO-1).
- Output register: on the last-sample transfer, sto_TDATA <= sat(y) and sto_TVALID <= 1. Otherwise, on an output transfer, sto_TVALID <= 0.
  - If an output transfer and a new last-sample transfer occur in the same cycle, the new sample is loaded and sto_TVALID stays 1.
- Latency: sto_TVALID rises on the edge following the last input transfer of a block, i.e. 1 cycle.
- Throughput: one input per cycle when sto_TREADY=1. With D=1, the output stream equals the (shifted, saturated) input stream delayed by 1 cycle.
- cfg_avg and cfg_shr are sampled at the last-sample transfer. Changing them mid-block affects only the block being closed.
- With sto_TREADY=0 and sto_TVALID=1, sti_TREADY=0. No input is lost, and the counter and accumulator hold.
- cfg_shr values > CW are clamped to CW.

Test Plan:
- Reset, then D=1, avg=1, shr=0; input 100, -5, 32767 with sto_TREADY=1 → outputs 100, -5, 32767, each 1 cycle after its input; sti_TREADY stays 1.
- D=4, avg=1, shr=2; input 4, 8, 12, 16, then 1, 1, 1, 1 → outputs 10 then 1; sto_TVALID asserted exactly once per 4 transfers.
- D=4, avg=1, shr=0; input 4×32767 → sum 131068 saturates to 32767. Input 4×-32768 → output -32768.
- D=3, avg=0; input 7, -9, 42 → output 42. cfg_dec=0 behaves identically to D=1.
- Backpressure: D=2, hold sto_TREADY=0 after the first output is produced → sti_TREADY=0, the output holds its value and input stalls. Release → the next block's result follows with no sample dropped or duplicated.
- Mid-operation events:
  - Assert ctl_rst after 2 of 4 samples → sto_TVALID=0, and the next 4 inputs 1, 2, 3, 4 (shr=2) yield 2.
  - Change cfg_dec 8→2 at cnt=5 → the block closes on the next transfer.

Source files
------------

// File: rtl/scope_dec_avg_sat_if.sv
// rtl/scope_dec_avg_sat_if.sv - valid/ready sample stream bundle
interface scope_dec_avg_sat_if #(
    parameter int W = 16
);
    logic [W-1:0] TDATA;
    logic         TVALID;
    logic         TREADY;

    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/scope_dec_avg_sat.sv
// rtl/scope_dec_avg_sat.sv - decimator emitting block average or last sample, saturated
module scope_dec_avg_sat #(
    parameter int DWI = 16,
    parameter int DWO = 16,
    parameter int CW  = 17,
    parameter int SW  = 5
) (
    input  logic                 ACLK,
    input  logic                 ctl_rst,
    input  logic                 cfg_avg,
    input  logic [CW-1:0]        cfg_dec,
    input  logic [SW-1:0]        cfg_shr,
    scope_dec_avg_sat_if.slave   sti,
    scope_dec_avg_sat_if.master  sto
);
    localparam int AW = DWI + CW;
    localparam logic signed [AW-1:0] SMAX = {{(AW-DWO+1){1'b0}}, {(DWO-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    logic [CW-1:0]        r_cnt;
    logic signed [AW-1:0] r_acc;
    logic [DWO-1:0]       r_data;
    logic                 r_valid;

    logic                 w_in_xfer;
    logic [CW-1:0]        w_d;
    logic                 w_last;
    logic signed [AW-1:0] w_x;
    logic signed [AW-1:0] w_sum;
    logic [SW-1:0]        w_shr;
    logic signed [AW-1:0] w_y;
    logic [DWO-1:0]       w_sat;

    assign sti.TREADY = sto.TREADY | ~r_valid;
    assign sto.TDATA  = r_data;
    assign sto.TVALID = r_valid;

    assign w_in_xfer = sti.TVALID & sti.TREADY;
    assign w_d       = (cfg_dec == '0) ? CW'(1) : cfg_dec;
    // >= lets a shrunken factor close an already-long block on the next sample
    assign w_last    = (r_cnt >= w_d - CW'(1));
    assign w_x       = {{CW{sti.TDATA[DWI-1]}}, sti.TDATA};
    assign w_sum     = (r_cnt == '0) ? w_x : r_acc + w_x;
    assign w_shr     = (cfg_shr > SW'(CW)) ? SW'(CW) : cfg_shr;
    assign w_y       = cfg_avg ? (w_sum >>> w_shr) : w_x;
    assign w_sat     = (w_y > SMAX) ? SMAX[DWO-1:0] :
                       (w_y < SMIN) ? SMIN[DWO-1:0] : w_y[DWO-1:0];

    always_ff @(posedge ACLK) begin
        if (ctl_rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_acc <= w_sum;
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            if (w_in_xfer && w_last) begin
                r_data  <= w_sat;
                r_valid <= 1'b1;
            end else if (sto.TREADY) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_scope_dec_avg_sat.sv
// tb/tb_scope_dec_avg_sat.sv - table, directed and randomized checks of scope_dec_avg_sat
module tb_scope_dec_avg_sat;
    logic        ACLK = 1'b0;
    logic        ctl_rst = 1'b1;
    logic        cfg_avg = 1'b0;
    logic [16:0] cfg_dec = 17'd1;
    logic [4:0]  cfg_shr = 5'd0;

    scope_dec_avg_sat_if #(.W(16)) sti ();
    scope_dec_avg_sat_if #(.W(16)) sto ();

    scope_dec_avg_sat #(.DWI(16), .DWO(16), .CW(17), .SW(5)) dut (
        .ACLK    (ACLK),
        .ctl_rst (ctl_rst),
        .cfg_avg (cfg_avg),
        .cfg_dec (cfg_dec),
        .cfg_shr (cfg_shr),
        .sti     (sti),
        .sto     (sto)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [16:0]      dec;
        logic             avg;
        logic [4:0]       shr;
        logic [3:0]       n;
        logic [7:0][15:0] x;
        logic [3:0]       ne;
        logic [3:0][15:0] y;
    } vec_t;

    int total = 0;
    int bad = 0;
    int blk[$];
    int exp_q[$];
    int got_q[$];
    bit chk_lat = 1'b0;
    bit rdone = 1'b0;
    int rnd_outputs = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: collect the block, close it once it holds D samples, then average or pick.
    always @(negedge ACLK) begin
        if (ctl_rst) begin
            blk.delete();
            exp_q.delete();
            chk_lat = 1'b0;
        end else begin
            if (chk_lat) begin
                check("latency_valid", sto.TVALID, 1);
                chk_lat = 1'b0;
            end
            if (sto.TVALID && sto.TREADY) begin
                int got;
                got = $signed(sto.TDATA);
                got_q.push_back(got);
                rnd_outputs++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_output: got %0d expected none", got);
                end else begin
                    check("stream_data", got, exp_q.pop_front());
                end
            end
            if (sti.TVALID && sti.TREADY) begin
                int d;
                int xs;
                xs = $signed(sti.TDATA);
                blk.push_back(xs);
                d = (cfg_dec == 0) ? 1 : int'(cfg_dec);
                if (blk.size() >= d) begin
                    longint s;
                    longint y;
                    int sh;
                    s = 0;
                    foreach (blk[i]) s += blk[i];
                    sh = (cfg_shr > 17) ? 17 : int'(cfg_shr);
                    y = cfg_avg ? (s >>> sh) : longint'(xs);
                    if (y > 32767) y = 32767;
                    if (y < -32768) y = -32768;
                    exp_q.push_back(int'(y));
                    blk.delete();
                    chk_lat = 1'b1;
                end
            end
        end
    end

    task automatic send(input int x);
        int n;
        n = 0;
        sti.TDATA = 16'(x);
        sti.TVALID = 1'b1;
        forever begin
            @(negedge ACLK);
            if (sti.TREADY) begin
                @(posedge ACLK);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
                break;
            end
        end
        sti.TVALID = 1'b0;
    endtask

    function automatic vec_t mk(input int dec, input int avg, input int shr, input int n,
                                input int x0, input int x1, input int x2, input int x3,
                                input int x4, input int x5, input int x6, input int x7,
                                input int ne, input int y0, input int y1, input int y2, input int y3);
        vec_t v;
        v.dec = 17'(dec); v.avg = avg[0]; v.shr = 5'(shr); v.n = 4'(n);
        v.x[0] = 16'(x0); v.x[1] = 16'(x1); v.x[2] = 16'(x2); v.x[3] = 16'(x3);
        v.x[4] = 16'(x4); v.x[5] = 16'(x5); v.x[6] = 16'(x6); v.x[7] = 16'(x7);
        v.ne = 4'(ne);
        v.y[0] = 16'(y0); v.y[1] = 16'(y1); v.y[2] = 16'(y2); v.y[3] = 16'(y3);
        return v;
    endfunction

    task automatic expect_got(input string nm, input int n, input int e0, input int e1);
        int e[2];
        e[0] = e0;
        e[1] = e1;
        repeat (3) @(negedge ACLK);
        check({nm, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < got_q.size()) check(nm, got_q[i], e[i]);
        @(posedge ACLK);
        #1;
    endtask

    vec_t  vecs[8];
    string names[8];

    initial begin
        vecs[0] = mk(1, 1, 0, 3, 100, -5, 32767, 0, 0, 0, 0, 0, 3, 100, -5, 32767, 0);
        names[0] = "d1_pass";
        vecs[1] = mk(4, 1, 2, 8, 4, 8, 12, 16, 1, 1, 1, 1, 2, 10, 1, 0, 0);
        names[1] = "d4_avg";
        vecs[2] = mk(4, 1, 0, 4, 32767, 32767, 32767, 32767, 0, 0, 0, 0, 1, 32767, 0, 0, 0);
        names[2] = "d4_sat_hi";
        vecs[3] = mk(4, 1, 0, 4, -32768, -32768, -32768, -32768, 0, 0, 0, 0, 1, -32768, 0, 0, 0);
        names[3] = "d4_sat_lo";
        vecs[4] = mk(3, 0, 0, 3, 7, -9, 42, 0, 0, 0, 0, 0, 1, 42, 0, 0, 0);
        names[4] = "d3_pick";
        vecs[5] = mk(0, 1, 0, 2, 3, -7, 0, 0, 0, 0, 0, 0, 2, 3, -7, 0, 0);
        names[5] = "d0_as_1";
        vecs[6] = mk(2, 1, 1, 2, -3, -4, 0, 0, 0, 0, 0, 0, 1, -4, 0, 0, 0);
        names[6] = "d2_neg_shift";
        vecs[7] = mk(8, 1, 31, 8, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                     1, 1, 0, 0, 0);
        names[7] = "shr_clamp";

        sti.TVALID = 1'b0;
        sti.TDATA = '0;
        sto.TREADY = 1'b0;
        ctl_rst = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_valid", sto.TVALID, 0);
        check("rst_data", sto.TDATA, 0);
        check("rst_in_ready", sti.TREADY, 1);
        @(posedge ACLK);
        #1;
        ctl_rst = 1'b0;
        sto.TREADY = 1'b1;

        for (int v = 0; v < 8; v++) begin
            cfg_dec = vecs[v].dec;
            cfg_avg = vecs[v].avg;
            cfg_shr = vecs[v].shr;
            got_q.delete();
            for (int i = 0; i < int'(vecs[v].n); i++) send(int'($signed(vecs[v].x[i])));
            repeat (3) @(negedge ACLK);
            check({names[v], "_count"}, got_q.size(), int'(vecs[v].ne));
            for (int i = 0; i < int'(vecs[v].ne); i++)
                if (i < got_q.size()) check(names[v], got_q[i], int'($signed(vecs[v].y[i])));
            @(posedge ACLK);
            #1;
        end

        // Output stall: result held, input blocked, then drains in order.
        cfg_dec = 17'd2; cfg_avg = 1'b1; cfg_shr = 5'd0;
        got_q.delete();
        send(5);
        send(7);
        sto.TREADY = 1'b0;
        fork
            begin
                send(1);
                send(2);
            end
            begin
                repeat (4) begin
                    @(negedge ACLK);
                    check("bp_in_ready", sti.TREADY, 0);
                    check("bp_valid", sto.TVALID, 1);
                    check("bp_data", $signed(sto.TDATA), 12);
                end
                @(posedge ACLK);
                #1;
                sto.TREADY = 1'b1;
            end
        join
        expect_got("bp_stream", 2, 12, 3);

        // Reset in the middle of a block discards the partial sum.
        cfg_dec = 17'd4; cfg_avg = 1'b1; cfg_shr = 5'd2;
        got_q.delete();
        send(9);
        send(9);
        ctl_rst = 1'b1;
        @(posedge ACLK);
        #1;
        ctl_rst = 1'b0;
        @(negedge ACLK);
        check("midrst_valid", sto.TVALID, 0);
        @(posedge ACLK);
        #1;
        for (int i = 1; i <= 4; i++) send(i);
        expect_got("midrst_avg", 1, 2, 0);

        // Shrinking the factor mid-block closes it on the next sample.
        cfg_dec = 17'd8; cfg_avg = 1'b1; cfg_shr = 5'd0;
        got_q.delete();
        for (int i = 1; i <= 5; i++) send(i);
        cfg_dec = 17'd2;
        send(10);
        send(3);
        send(4);
        expect_got("dec_shrink", 2, 25, 7);

        rnd_outputs = 0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    int x;
                    logic [15:0] r;
                    if ($urandom_range(0, 7) == 0) begin
                        cfg_dec = 17'($urandom_range(0, 5));
                        cfg_avg = 1'($urandom_range(0, 1));
                        cfg_shr = 5'($urandom_range(0, 31));
                    end
                    r = 16'($urandom);
                    case ($urandom_range(0, 3))
                        0: x = 32767;
                        1: x = -32768;
                        default: x = $signed(r);
                    endcase
                    send(x);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge ACLK);
                    #1;
                    sto.TREADY = ($urandom_range(0, 3) != 0);
                end
                sto.TREADY = 1'b1;
            end
        join
        repeat (6) @(negedge ACLK);
        check("rnd_drain", exp_q.size(), 0);
        check("rnd_outputs_seen", rnd_outputs > 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
